// File: rtl/ram_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed image from a byte stream,
// writes it into RAM from address 0, then hands the RAM write port to the CPU.
module ram_boot_loader #(
  parameter int unsigned Size = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      in_data_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            load_req_i,
  input  logic            cpu_wr_en_i,
  input  logic [Size-1:0] cpu_addr_i,
  input  logic [31:0]     cpu_data_i,
  output logic            cpu_rst_o,
  output logic            ram_wr_en_o,
  output logic [Size-1:0] ram_addr_o,
  output logic [31:0]     ram_data_o,
  output logic            done_o,
  output logic            err_o
);

  typedef enum logic [2:0] {
    StHdrHi, StHdrLo, StByte, StWrite, StChk, StRun, StErr
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [Size-1:0] addr_q, addr_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      csum_q, csum_d;
  logic [31:0]     word_q, word_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            accept;

  assign accept = in_valid_i && in_ready_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    word_d    = word_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    if (load_req_i) begin
      state_d   = StHdrHi;
      cnt_d     = '0;
      addr_d    = '0;
      idx_d     = '0;
      csum_d    = '0;
      word_d    = '0;
      cpu_rst_d = 1'b1;
      done_d    = 1'b0;
      err_d     = 1'b0;
    end else begin
      unique case (state_q)
        StHdrHi: if (accept) begin
          cnt_d   = {in_data_i, cnt_q[7:0]};
          addr_d  = '0;
          idx_d   = '0;
          csum_d  = '0;
          state_d = StHdrLo;
        end
        StHdrLo: if (accept) begin
          cnt_d   = {cnt_q[15:8], in_data_i};
          state_d = (cnt_d != 16'd0) ? StByte : StChk;
        end
        StByte: if (accept) begin
          word_d = {word_q[23:0], in_data_i};
          csum_d = csum_q ^ in_data_i;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StWrite;
        end
        StWrite: begin
          addr_d  = addr_q + Size'(1);
          cnt_d   = cnt_q - 16'd1;
          state_d = (cnt_q == 16'd1) ? StChk : StByte;
        end
        StChk: if (accept) begin
          if (in_data_i == csum_q) begin
            state_d   = StRun;
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are gated by rst so the reset values hold from the first rst cycle.
  always_comb begin
    in_ready_o  = 1'b0;
    ram_wr_en_o = 1'b0;
    ram_addr_o  = '0;
    ram_data_o  = '0;
    if (!rst) begin
      unique case (state_q)
        StHdrHi, StHdrLo, StByte, StChk: in_ready_o = !load_req_i;
        StWrite: begin
          ram_wr_en_o = 1'b1;
          ram_addr_o  = addr_q;
          ram_data_o  = word_q;
        end
        StRun: begin
          ram_wr_en_o = cpu_wr_en_i;
          ram_addr_o  = cpu_addr_i;
          ram_data_o  = cpu_data_i;
        end
        default: ;
      endcase
    end
  end

  assign cpu_rst_o = cpu_rst_q || rst;
  assign done_o    = done_q && !rst;
  assign err_o     = err_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StHdrHi;
      cnt_q     <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      word_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      word_q    <= word_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule
